// File: rtl/gt_reset_sequencer_if.sv
// GT channel reset/status bundle between the reset sequencer and the GT/link side.
// The sequencer uses the master modport; the GT channel model uses the slave modport.
interface gt_reset_sequencer_if;
  logic       CPLLLOCK_IN;
  logic       TXRESETDONE_IN;
  logic       RXRESETDONE_IN;
  logic       CPLLRESET_OUT;
  logic       GTTXRESET_OUT;
  logic       GTRXRESET_OUT;
  logic       TXUSERRDY_OUT;
  logic       RXUSERRDY_OUT;
  logic       DONE_OUT;
  logic       FAIL_OUT;
  logic [3:0] RETRY_COUNT_OUT;

  modport master (
    input  CPLLLOCK_IN, TXRESETDONE_IN, RXRESETDONE_IN,
    output CPLLRESET_OUT, GTTXRESET_OUT, GTRXRESET_OUT, TXUSERRDY_OUT,
           RXUSERRDY_OUT, DONE_OUT, FAIL_OUT, RETRY_COUNT_OUT
  );

  modport slave (
    output CPLLLOCK_IN, TXRESETDONE_IN, RXRESETDONE_IN,
    input  CPLLRESET_OUT, GTTXRESET_OUT, GTRXRESET_OUT, TXUSERRDY_OUT,
           RXUSERRDY_OUT, DONE_OUT, FAIL_OUT, RETRY_COUNT_OUT
  );
endinterface

// File: rtl/gt_reset_sequencer.sv
// GTX channel + CPLL startup controller: CPLL reset, lock wait, GT reset release,
// USERRDY assertion and reset-done confirmation with bounded retries.
module gt_reset_sequencer #(
  parameter int WAIT_STARTUP_CYCLES = 300,
  parameter int LOCK_TIMEOUT        = 50000,
  parameter int DONE_TIMEOUT        = 50000,
  parameter int USRCLK_WAIT_CYCLES  = 16,
  parameter int MAX_RETRIES         = 3
) (
  input logic                   SYSCLK_IN,
  input logic                   SOFT_RESET_IN,
  gt_reset_sequencer_if.master  gt_if
);

  typedef enum logic [2:0] {
    INIT_WAIT      = 3'd0,
    CPLL_RESET     = 3'd1,
    WAIT_CPLLLOCK  = 3'd2,
    GT_RESET_HOLD  = 3'd3,
    WAIT_USRCLK    = 3'd4,
    WAIT_RESETDONE = 3'd5,
    DONE           = 3'd6,
    FAIL           = 3'd7
  } state_e;

  localparam logic [15:0] INIT_LAST   = 16'(WAIT_STARTUP_CYCLES);
  localparam logic [15:0] HOLD_LAST   = 16'd3;
  localparam logic [15:0] USRCLK_LAST = 16'(USRCLK_WAIT_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] DONE_LAST   = 16'(DONE_TIMEOUT);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [3:0]  retry_q;
  logic [2:0]  sync1_q;
  logic [2:0]  sync2_q;
  logic        cpllreset_q;
  logic        gttxreset_q;
  logic        gtrxreset_q;
  logic        txuserrdy_q;
  logic        rxuserrdy_q;
  logic        done_q;
  logic        fail_q;
  logic        lock_s;
  logic        txdone_s;
  logic        rxdone_s;
  logic        retry_req_s;

  always_ff @(posedge SYSCLK_IN) begin
    if (SOFT_RESET_IN) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {gt_if.CPLLLOCK_IN, gt_if.TXRESETDONE_IN, gt_if.RXRESETDONE_IN};
      sync2_q <= sync1_q;
    end
  end

  assign lock_s   = sync2_q[2];
  assign txdone_s = sync2_q[1];
  assign rxdone_s = sync2_q[0];

  // Lock loss while the GT is being brought up, or a timeout, forces a retry;
  // a success condition seen on the timeout cycle takes precedence.
  always_comb begin
    retry_req_s = 1'b0;
    case (state_q)
      WAIT_CPLLLOCK:              retry_req_s = !lock_s && (cnt_q == LOCK_LAST);
      GT_RESET_HOLD, WAIT_USRCLK: retry_req_s = !lock_s;
      WAIT_RESETDONE:             retry_req_s = !lock_s ||
                                    (!(txdone_s && rxdone_s) && (cnt_q == DONE_LAST));
      default:                    retry_req_s = 1'b0;
    endcase
  end

  always_ff @(posedge SYSCLK_IN) begin
    if (SOFT_RESET_IN) begin
      state_q     <= INIT_WAIT;
      cnt_q       <= 16'd0;
      retry_q     <= 4'd0;
      cpllreset_q <= 1'b0;
      gttxreset_q <= 1'b1;
      gtrxreset_q <= 1'b1;
      txuserrdy_q <= 1'b0;
      rxuserrdy_q <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else if (retry_req_s) begin
      cnt_q       <= 16'd0;
      gttxreset_q <= 1'b1;
      gtrxreset_q <= 1'b1;
      txuserrdy_q <= 1'b0;
      rxuserrdy_q <= 1'b0;
      if (retry_q < RETRY_MAX) begin
        retry_q     <= retry_q + 4'd1;
        cpllreset_q <= 1'b1;
        state_q     <= CPLL_RESET;
      end else begin
        fail_q  <= 1'b1;
        state_q <= FAIL;
      end
    end else begin
      cnt_q <= cnt_q + 16'd1;
      case (state_q)
        INIT_WAIT: begin
          if (cnt_q == INIT_LAST) begin
            cnt_q       <= 16'd0;
            cpllreset_q <= 1'b1;
            state_q     <= CPLL_RESET;
          end
        end
        CPLL_RESET: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q       <= 16'd0;
            cpllreset_q <= 1'b0;
            state_q     <= WAIT_CPLLLOCK;
          end
        end
        WAIT_CPLLLOCK: begin
          if (lock_s) begin
            cnt_q   <= 16'd0;
            state_q <= GT_RESET_HOLD;
          end
        end
        GT_RESET_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q       <= 16'd0;
            gttxreset_q <= 1'b0;
            gtrxreset_q <= 1'b0;
            state_q     <= WAIT_USRCLK;
          end
        end
        WAIT_USRCLK: begin
          if (cnt_q == USRCLK_LAST) begin
            cnt_q       <= 16'd0;
            txuserrdy_q <= 1'b1;
            rxuserrdy_q <= 1'b1;
            state_q     <= WAIT_RESETDONE;
          end
        end
        WAIT_RESETDONE: begin
          if (txdone_s && rxdone_s) begin
            cnt_q   <= 16'd0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        // Only CPLL lock loss restarts a running link; reset-done glitches are ignored.
        DONE: begin
          if (!lock_s) begin
            cnt_q       <= 16'd0;
            done_q      <= 1'b0;
            retry_q     <= 4'd0;
            gttxreset_q <= 1'b1;
            gtrxreset_q <= 1'b1;
            txuserrdy_q <= 1'b0;
            rxuserrdy_q <= 1'b0;
            cpllreset_q <= 1'b1;
            state_q     <= CPLL_RESET;
          end
        end
        FAIL: begin
          fail_q      <= 1'b1;
          gttxreset_q <= 1'b1;
          gtrxreset_q <= 1'b1;
        end
        default: begin
          cnt_q   <= 16'd0;
          state_q <= INIT_WAIT;
        end
      endcase
    end
  end

  assign gt_if.CPLLRESET_OUT   = cpllreset_q;
  assign gt_if.GTTXRESET_OUT   = gttxreset_q;
  assign gt_if.GTRXRESET_OUT   = gtrxreset_q;
  assign gt_if.TXUSERRDY_OUT   = txuserrdy_q;
  assign gt_if.RXUSERRDY_OUT   = rxuserrdy_q;
  assign gt_if.DONE_OUT        = done_q;
  assign gt_if.FAIL_OUT        = fail_q;
  assign gt_if.RETRY_COUNT_OUT = retry_q;

endmodule

// File: doc/gt_reset_sequencer.md
# gt_reset_sequencer

Synchronous reset/startup controller for one GTX channel and its CPLL. It sequences CPLL reset, waits for lock, releases TX and RX PCS/PMA reset, asserts USERRDY once the user clocks are stable, and confirms TX/RX reset-done. It sits beside the GT user-clock source in the free-running system clock domain. It drives the GT channel's reset pins and gives the SATA link layer a single `DONE_OUT`/`FAIL_OUT` status.

## Interface
- `WAIT_STARTUP_CYCLES`, default 300: idle cycles after reset before the first CPLL reset.
- `LOCK_TIMEOUT`, default 50000: maximum cycles spent in `WAIT_CPLLLOCK`.
- `DONE_TIMEOUT`, default 50000: maximum cycles spent in `WAIT_RESETDONE`.
- `USRCLK_WAIT_CYCLES`, default 16: cycles between GT reset release and USERRDY assertion.
- `MAX_RETRIES`, default 3: retries allowed before the block declares failure (1..15).

Ports:
- `SYSCLK_IN`, in, 1: free-running stable clock. The only clock in the block.
- `SOFT_RESET_IN`, in, 1: reset; synchronous, active-high.
- `CPLLLOCK_IN`, in, 1: CPLL lock, asynchronous to `SYSCLK_IN`.
- `TXRESETDONE_IN`, in, 1: GT TX reset done, asynchronous.
- `RXRESETDONE_IN`, in, 1: GT RX reset done, asynchronous.
- `CPLLRESET_OUT`, out, 1: CPLL reset pulse.
- `GTTXRESET_OUT`, out, 1: GT TX reset.
- `GTRXRESET_OUT`, out, 1: GT RX reset.
- `TXUSERRDY_OUT`, out, 1: TX user clocks are stable.
- `RXUSERRDY_OUT`, out, 1: RX user clocks are stable.
- `DONE_OUT`, out, 1: channel is up.
- `FAIL_OUT`, out, 1: retries are exhausted. Sticky until reset.
- `RETRY_COUNT_OUT`, out, 4: retries consumed in the current bring-up.

## Operation
- `CPLLLOCK_IN`, `TXRESETDONE_IN` and `RXRESETDONE_IN` each pass through a 2-flop synchronizer. The FSM sees only the synced versions (`lock_s`, `txdone_s`, `rxdone_s`).
- All outputs are registered.
- Reset values: `GTTXRESET_OUT`=1 and `GTRXRESET_OUT`=1. Every other output is 0, including `RETRY_COUNT_OUT`=0. The state is `INIT_WAIT` and the counter is 0.
- One shared 16-bit cycle counter. It clears on every state entry.

States and transitions:
- `INIT_WAIT`: after `WAIT_STARTUP_CYCLES` cycles, go to `CPLL_RESET`.
- `CPLL_RESET`: `CPLLRESET_OUT`=1 for exactly 4 cycles, then go to `WAIT_CPLLLOCK`.
- `WAIT_CPLLLOCK`:
  - On `lock_s`=1, go to `GT_RESET_HOLD`.
  - When the counter reaches `LOCK_TIMEOUT`, take the RETRY path.
- `GT_RESET_HOLD`: keep both GT resets high for 4 cycles, then deassert both and go to `WAIT_USRCLK`.
- `WAIT_USRCLK`: after `USRCLK_WAIT_CYCLES` cycles, set `TXUSERRDY_OUT` and `RXUSERRDY_OUT` to 1 and go to `WAIT_RESETDONE`.
- `WAIT_RESETDONE`:
  - When `txdone_s` and `rxdone_s` are both 1, go to `DONE` with `DONE_OUT`=1.
  - When the counter reaches `DONE_TIMEOUT`, take the RETRY path.
- `DONE`:
  - If `lock_s` falls, `DONE_OUT` goes to 0 next cycle, `RETRY_COUNT_OUT` clears to 0, and the FSM goes to `CPLL_RESET`.
  - A fall of `txdone_s`/`rxdone_s` alone is ignored.
- RETRY path:
  - Both GT resets return to 1 and both USERRDY outputs return to 0.
  - If `RETRY_COUNT_OUT` is less than `MAX_RETRIES`: increment it and go to `CPLL_RESET`.
  - Otherwise go to `FAIL`.
  - Loss of `lock_s` in `GT_RESET_HOLD`, `WAIT_USRCLK` or `WAIT_RESETDONE` also takes the RETRY path.
- `FAIL`: `FAIL_OUT`=1 and both GT resets are 1. The block stays here until `SOFT_RESET_IN`.

General rules:
- The GT resets are high in every state except `WAIT_USRCLK`, `WAIT_RESETDONE` and `DONE`.
- USERRDY is high only in `WAIT_RESETDONE` and `DONE`.
- Total bring-up attempts = `MAX_RETRIES` + 1.

## Timing
- Edge 0 is the first rising edge with `SOFT_RESET_IN` sampled low.
- `CPLLRESET_OUT` is high after edge `WAIT_STARTUP_CYCLES` and low after edge `WAIT_STARTUP_CYCLES`+4.
- Synchronizer latency is 2 cycles. A raw input change is acted on by the FSM 3 edges later.
- GT resets fall 4 cycles after `GT_RESET_HOLD` entry, i.e. 7 cycles after the raw lock rise.
- USERRDY rises `USRCLK_WAIT_CYCLES` cycles after the GT reset fall.
- `DONE_OUT` rises 3 cycles after the later of the raw TX/RX done rises, provided USERRDY is already high.
- Simultaneous events in one cycle:
  - Condition and timeout together: the condition wins.
  - `SOFT_RESET_IN` wins over everything.
  - A reset in the middle of a sequence restores all reset values on the next edge.

## Test plan
- Nominal bring-up (`WAIT_STARTUP_CYCLES`=10, `USRCLK_WAIT_CYCLES`=8; lock raw-high at edge 30, both done raw-high at edge 60) -> `CPLLRESET_OUT` high over edges 10..13; GT resets fall at edge 37; USERRDY rises at edge 45; `DONE_OUT`=1 at edge 63; `RETRY_COUNT_OUT`=0.
- Lock timeout (`LOCK_TIMEOUT`=100, `MAX_RETRIES`=2, lock never asserts) -> 3 `CPLLRESET_OUT` pulses; `RETRY_COUNT_OUT` steps 1 then 2; `FAIL_OUT`=1; GT resets stay 1; `DONE_OUT` stays 0.
- Done timeout, then success on retry (only TX done arrives in the first attempt; both arrive in the second) -> `RETRY_COUNT_OUT`=1; USERRDY drops, then reasserts; `DONE_OUT`=1.
- Lock loss in `DONE` (drop `CPLLLOCK_IN` for 20 cycles) -> `DONE_OUT`=0 3 cycles after the raw drop; both GT resets are 1; `RETRY_COUNT_OUT`=0; a new `CPLLRESET_OUT` pulse follows; the block re-reaches `DONE` after lock returns.
- Reset during `WAIT_USRCLK` (assert `SOFT_RESET_IN` for 1 cycle) -> next edge: GT resets are 1, USERRDY, DONE and FAIL are 0, `RETRY_COUNT_OUT`=0; the sequence restarts from `INIT_WAIT`.
- Simultaneous lock and timeout (raise lock so that `lock_s` rises exactly on the cycle the counter hits `LOCK_TIMEOUT`) -> the FSM enters `GT_RESET_HOLD`; `RETRY_COUNT_OUT` stays unchanged.
